// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - clipped solid-colour rectangle fill into the pixel framebuffer
//
// Purpose: accepts one rectangle fill command at a time, clips it to the
// buffer bounds and emits one framebuffer write per pixel in raster order,
// honouring write backpressure.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready    command handshake
//   cmd_x0, cmd_y0     top-left corner of the rectangle
//   cmd_w, cmd_h       rectangle size in pixels
//   cmd_color          12-bit pixel value {B, G, R}
//   wr_en/ready        framebuffer write handshake
//   wr_addr, wr_data   pixel address (y*BUFFER_WIDTH + x) and value
//   busy               command in progress (DRAW or DONE)
//   done               one-cycle pulse when a command completes
module framebuffer_writer #(
   parameter int BUFFER_WIDTH  = 320,
   parameter int BUFFER_HEIGHT = 240,
   parameter int ADDR_WIDTH    = 32,
   parameter int XW            = $clog2(BUFFER_WIDTH + 1),
   parameter int YW            = $clog2(BUFFER_HEIGHT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [XW-1:0]         cmd_x0,
   input  logic [YW-1:0]         cmd_y0,
   input  logic [XW-1:0]         cmd_w,
   input  logic [YW-1:0]         cmd_h,
   input  logic [11:0]           cmd_color,
   output logic                  wr_en,
   input  logic                  wr_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [11:0]           wr_data,
   output logic                  busy,
   output logic                  done
);

   localparam int XE = XW + 1;
   localparam int YE = YW + 1;
   localparam int AW = ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [XW-1:0] x0_q;
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic [XE-1:0] x_end;
   logic [YE-1:0] y_end;
   logic [AW-1:0] row_base;
   logic [11:0]   color_q;

   logic          accept;
   logic          empty_cmd;
   logic [XE-1:0] x_sum;
   logic [YE-1:0] y_sum;
   logic [XE-1:0] x_end_clip;
   logic [YE-1:0] y_end_clip;
   logic          handshake;
   logic          row_end;
   logic          last_row;

   // Extra sum bit keeps x0+w / y0+h from wrapping before the clip.
   assign x_sum      = {1'b0, cmd_x0} + {1'b0, cmd_w};
   assign y_sum      = {1'b0, cmd_y0} + {1'b0, cmd_h};
   assign x_end_clip = (x_sum > XE'(BUFFER_WIDTH))  ? XE'(BUFFER_WIDTH)  : x_sum;
   assign y_end_clip = (y_sum > YE'(BUFFER_HEIGHT)) ? YE'(BUFFER_HEIGHT) : y_sum;

   assign empty_cmd = (cmd_w == '0) || (cmd_h == '0) ||
                      ({1'b0, cmd_x0} >= XE'(BUFFER_WIDTH)) ||
                      ({1'b0, cmd_y0} >= YE'(BUFFER_HEIGHT));

   assign accept    = cmd_valid && cmd_ready;
   assign handshake = wr_en && wr_ready;
   assign row_end   = ({1'b0, cx} + XE'(1)) == x_end;
   assign last_row  = ({1'b0, cy} + YE'(1)) == y_end;

   assign wr_addr = row_base + AW'(cx);
   assign wr_data = color_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      wr_en      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            // Held low while rst is asserted so nothing is accepted during reset.
            cmd_ready = !rst;
            if (cmd_valid && !rst) begin
               state_next = empty_cmd ? DONE : DRAW;
            end
         end
         DRAW: begin
            wr_en = 1'b1;
            busy  = 1'b1;
            if (wr_ready && row_end && last_row) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x0_q     <= '0;
         cx       <= '0;
         cy       <= '0;
         x_end    <= '0;
         y_end    <= '0;
         row_base <= '0;
         color_q  <= '0;
      end else if (state == IDLE) begin
         // Empty commands leave the pointers alone so wr_addr never points outside the buffer.
         if (accept && !empty_cmd) begin
            x0_q     <= cmd_x0;
            cx       <= cmd_x0;
            cy       <= cmd_y0;
            x_end    <= x_end_clip;
            y_end    <= y_end_clip;
            row_base <= AW'(cmd_y0) * AW'(BUFFER_WIDTH);
            color_q  <= cmd_color;
         end
      end else if (state == DRAW && handshake) begin
         if (row_end) begin
            cx <= x0_q;
            if (!last_row) begin
               cy       <= cy + YW'(1);
               row_base <= row_base + AW'(BUFFER_WIDTH);
            end
         end else begin
            cx <= cx + XW'(1);
         end
      end
   end

endmodule
